conv_2d: RTL and testbench

CONV_2D -- requirements
Module: conv_2d

---
 rtl/conv_2d.sv | 56 +++++
 tb/tb_conv_2d.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/conv_2d.sv
// 3x3 signed convolution: kernel and pixel window are 3-column shift registers,
// and o_pixel registers the full-precision dot product of the pre-edge contents.
module conv_2d (
  input  logic               clk,
  input  logic               i_nrst,
  input  logic               i_load_knl,
  input  logic               i_en_conv,
  input  logic signed [7:0]  i_data1,
  input  logic signed [7:0]  i_data2,
  input  logic signed [7:0]  i_data3,
  output logic signed [20:0] o_pixel
);

  // Indexed [column][row]; column 0 is the oldest column.
  logic signed [7:0]  knl  [3][3];
  logic signed [7:0]  win  [3][3];
  logic signed [15:0] prod [3][3];
  logic signed [20:0] sum;

  always_comb begin
    sum = '0;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        prod[c][r] = knl[c][r] * win[c][r];
        sum = sum + {{5{prod[c][r][15]}}, prod[c][r]};
      end
    end
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int c = 0; c < 3; c++) begin
        for (int r = 0; r < 3; r++) begin
          knl[c][r] <= '0;
          win[c][r] <= '0;
        end
      end
      o_pixel <= '0;
    end else if (i_load_knl) begin
      // Kernel load wins over convolution; window and result hold.
      knl[0] <= knl[1];
      knl[1] <= knl[2];
      knl[2][0] <= i_data1;
      knl[2][1] <= i_data2;
      knl[2][2] <= i_data3;
    end else if (i_en_conv) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2][0] <= i_data1;
      win[2][1] <= i_data2;
      win[2][2] <= i_data3;
      o_pixel <= sum;
    end
  end

endmodule

// File: tb/tb_conv_2d.sv
// Directed and randomized bench for conv_2d against an integer reference model.
module tb_conv_2d;

  logic               clk;
  logic               i_nrst;
  logic               i_load_knl;
  logic               i_en_conv;
  logic signed [7:0]  i_data1;
  logic signed [7:0]  i_data2;
  logic signed [7:0]  i_data3;
  logic signed [20:0] o_pixel;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integers, [column][row].
  int mk [3][3];
  int mw [3][3];
  int mo;

  conv_2d dut (
    .clk       (clk),
    .i_nrst    (i_nrst),
    .i_load_knl(i_load_knl),
    .i_en_conv (i_en_conv),
    .i_data1   (i_data1),
    .i_data2   (i_data2),
    .i_data3   (i_data3),
    .o_pixel   (o_pixel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [20:0] obs, input logic signed [20:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++) begin
        mk[c][r] = 0;
        mw[c][r] = 0;
      end
    mo = 0;
  endtask

  function automatic int model_sum();
    int s = 0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        s += mk[c][r] * mw[c][r];
    return s;
  endfunction

  // Apply one cycle of inputs, advance the model, check o_pixel after the edge.
  task automatic step(input string tag, input logic ld, input logic en,
                      input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int col [3];
    i_load_knl = ld;
    i_en_conv  = en;
    i_data1 = a;
    i_data2 = b;
    i_data3 = c;
    col[0] = int'($signed(a));
    col[1] = int'($signed(b));
    col[2] = int'($signed(c));
    @(posedge clk);
    if (i_nrst) begin
      if (ld) begin
        mk[0] = mk[1];
        mk[1] = mk[2];
        mk[2] = col;
      end else if (en) begin
        mo = model_sum();
        mw[0] = mw[1];
        mw[1] = mw[2];
        mw[2] = col;
      end
    end
    #1;
    check(tag, o_pixel, 21'(mo));
  endtask

  task automatic step_rand(input string tag, input logic ld, input logic en);
    step(tag, ld, en, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic do_reset();
    i_nrst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    i_nrst = 1'b1;
  endtask

  logic signed [20:0] sharpen_exp [4];
  logic signed [20:0] held;

  initial begin
    sharpen_exp[0] = 21'sd0;
    sharpen_exp[1] = -21'sd10880;
    sharpen_exp[2] = -21'sd32215;
    sharpen_exp[3] = -21'sd43095;
    i_load_knl = 1'b0;
    i_en_conv  = 1'b0;
    i_data1 = '0;
    i_data2 = '0;
    i_data3 = '0;
    model_reset();

    // Reset held with random activity: output stays zero.
    i_nrst = 1'b0;
    #2;
    for (int i = 0; i < 6; i++)
      step_rand("reset_hold", 1'($urandom), 1'($urandom));
    check("reset_hold_literal", o_pixel, 21'sd0);
    i_nrst = 1'b1;

    // Zero kernel after reset: convolution yields 0.
    for (int i = 0; i < 4; i++)
      step_rand("zero_kernel", 1'b0, 1'b1);
    check("zero_kernel_literal", o_pixel, 21'sd0);

    // Sharpen stream.
    do_reset();
    step("sharpen_load", 1'b1, 1'b0, 8'h00, 8'h80, 8'h00);
    step("sharpen_load", 1'b1, 1'b0, 8'h80, 8'h05, 8'h80);
    step("sharpen_load", 1'b1, 1'b0, 8'h00, 8'h80, 8'h00);
    for (int i = 0; i < 7; i++) begin
      step("sharpen_conv", 1'b0, 1'b1, 8'h44, 8'h55, 8'h66);
      check("sharpen_literal", o_pixel, sharpen_exp[(i < 3) ? i : 3]);
    end

    // Hold mid-stream with random data on the bus.
    for (int i = 0; i < 3; i++)
      step_rand("stream_pre_hold", 1'b0, 1'b1);
    held = o_pixel;
    for (int i = 0; i < 5; i++) begin
      step_rand("hold", 1'b0, 1'b0);
      check("hold_const", o_pixel, held);
    end
    for (int i = 0; i < 4; i++)
      step_rand("resume", 1'b0, 1'b1);

    // Load and enable together: window and output hold, kernel shifts.
    held = o_pixel;
    step_rand("priority", 1'b1, 1'b1);
    check("priority_hold", o_pixel, held);
    for (int i = 0; i < 3; i++)
      step_rand("post_priority", 1'b0, 1'b1);

    // Randomized mix of loads, convolutions and idles.
    for (int i = 0; i < 300; i++)
      step_rand("random_mix", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));

    // Extremes.
    for (int i = 0; i < 3; i++)
      step("ext_load_neg", 1'b1, 1'b0, 8'h80, 8'h80, 8'h80);
    for (int i = 0; i < 4; i++)
      step("ext_conv_neg", 1'b0, 1'b1, 8'h80, 8'h80, 8'h80);
    step("ext_conv_neg", 1'b0, 1'b1, 8'h80, 8'h80, 8'h80);
    check("ext_max_literal", o_pixel, 21'sd147456);
    for (int i = 0; i < 3; i++)
      step("ext_load_pos", 1'b1, 1'b0, 8'h7f, 8'h7f, 8'h7f);
    step("ext_conv_pos", 1'b0, 1'b1, 8'h80, 8'h80, 8'h80);
    check("ext_min_literal", o_pixel, -21'sd146304);

    // Asynchronous reset mid-cycle clears immediately.
    #3;
    i_nrst = 1'b0;
    model_reset();
    #1;
    check("async_reset", o_pixel, 21'sd0);
    @(posedge clk);
    #1;
    i_nrst = 1'b1;

    // Reset mid-load discards partial kernel.
    step_rand("partial_load", 1'b1, 1'b0);
    step_rand("partial_load", 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++)
      step_rand("after_partial_reset", 1'b0, 1'b1);
    check("after_partial_literal", o_pixel, 21'sd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
